// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and types for the cacheline adaptor.
// Line/beat geometry, FSM state encoding and an address-alignment helper.
package cacheline_adaptor_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT      = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ADDR_LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } cla_state_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ADDR_LINE_MASK;
  endfunction

  function automatic int beat_lsb(input logic [CNT_W-1:0] cnt);
    return int'(cnt) * BURST_W;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cacheline reads/writes from the arbiter to 4-beat 64-bit
// memory bursts; one resp_o pulse per completed line.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  cla_state_t         state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [LINE_W-1:0]  line_buf_r, line_buf_nxt_s;
  logic [31:0]        addr_r, addr_nxt_s;
  logic               read_r, write_r, resp_r;
  logic [BURST_W-1:0] burst_r;
  logic               last_beat_s;

  assign last_beat_s = resp_i && (cnt_r == LAST_BEAT);

  // Next-state decode; read wins if the arbiter ever raises both requests.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (read_i) begin
          state_nxt_s = READ;
        end else if (write_i) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (last_beat_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = READ;
        end
      end
      WRITE: begin
        if (last_beat_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: beat counter, line buffer and latched address.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    line_buf_nxt_s = line_buf_r;
    addr_nxt_s     = addr_r;
    case (state_r)
      IDLE: begin
        if (read_i || write_i) begin
          addr_nxt_s     = line_align(address_i);
          cnt_nxt_s      = {CNT_W{1'b0}};
          line_buf_nxt_s = read_i ? line_buf_r : line_i;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      READ: begin
        if (resp_i) begin
          line_buf_nxt_s[beat_lsb(cnt_r) +: BURST_W] = burst_i;
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // State, datapath and registered bus outputs; reset discards any partial line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      line_buf_r <= {LINE_W{1'b0}};
      addr_r     <= 32'd0;
      read_r     <= 1'b0;
      write_r    <= 1'b0;
      resp_r     <= 1'b0;
      burst_r    <= {BURST_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      line_buf_r <= line_buf_nxt_s;
      addr_r     <= addr_nxt_s;
      read_r     <= (state_nxt_s == READ);
      write_r    <= (state_nxt_s == WRITE);
      resp_r     <= (state_nxt_s == DONE);
      // Outgoing beat tracks the counter, so it only moves on a strobe.
      burst_r    <= line_buf_nxt_s[beat_lsb(cnt_nxt_s) +: BURST_W];
    end
  end

  assign line_o    = line_buf_r;
  assign address_o = addr_r;
  assign read_o    = read_r;
  assign write_o   = write_r;
  assign resp_o    = resp_r;
  assign burst_o   = burst_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed and randomized lines
// against a transaction-level memory/arbiter model.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [LINE_W-1:0]  line_i, line_o;
  logic [31:0]        address_i, address_o;
  logic               read_i, write_i, resp_o;
  logic [BURST_W-1:0] burst_i, burst_o;
  logic               read_o, write_o, resp_i;

  int errors = 0;
  int checks = 0;
  bit illegal_seen = 1'b0;
  logic [LINE_W-1:0] last_line;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  // Protocol monitor: the arbiter must never raise read and write together.
  always @(posedge clk) begin
    if (read_i && write_i) illegal_seen <= 1'b1;
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line transaction. Memory strobes from mask (directed) or randomly.
  task automatic run_line(input bit is_read, input bit both, input logic [31:0] addr,
                          input logic [LINE_W-1:0] wline, input int gap,
                          input logic [63:0] mask, input bit use_mask, input int exp_resp_cyc);
    logic [LINE_W-1:0] exp_line;
    logic [31:0] exp_addr;
    int beats;
    int cyc;
    exp_addr  = {addr[31:5], 5'b00000};
    exp_line  = is_read ? last_line : wline;
    address_i = addr;
    line_i    = wline;
    read_i    = is_read;
    write_i   = !is_read || both;
    tick();
    cyc = 1;
    check_val("req_rise", 256'({read_o, write_o}), is_read ? 256'd2 : 256'd1);
    check_val("addr_align", 256'(address_o), 256'(exp_addr));
    beats = 0;
    while (beats < BEATS && cyc < 64) begin
      resp_i = use_mask ? mask[cyc] : ($urandom_range(0, gap) == 0);
      if (!is_read) check_val("burst_o", 256'(burst_o), 256'(wline[64*beats +: 64]));
      check_val("req_hold", 256'({read_o, write_o, resp_o}), is_read ? 256'd4 : 256'd2);
      check_val("addr_stable", 256'(address_o), 256'(exp_addr));
      if (resp_i && is_read) begin
        burst_i = use_mask ? {16{4'(beats + 1)}} : {$urandom, $urandom};
        exp_line[64*beats +: 64] = burst_i;
      end
      if (resp_i) beats++;
      tick();
      cyc++;
    end
    resp_i = 1'b0;
    check_val("beat_budget", 256'(beats), 256'(BEATS));
    check_val("resp_pulse", 256'({read_o, write_o, resp_o}), 256'd1);
    if (use_mask) check_val("resp_cycle", 256'(cyc), 256'(exp_resp_cyc));
    check_val("line_o", line_o, exp_line);
    last_line = exp_line;
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
    check_val("resp_once", 256'({read_o, write_o, resp_o}), 256'd0);
    check_val("addr_hold", 256'(address_o), 256'(exp_addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] rline;
    logic [31:0] raddr;
    reset_n   = 1'b0;
    line_i    = '0;
    address_i = 32'd0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    last_line = '0;
    tick();
    tick();
    check_val("rst_ctrl", 256'({read_o, write_o, resp_o}), 256'd0);
    check_val("rst_line", line_o, 256'd0);
    check_val("rst_burst", 256'(burst_o), 256'd0);
    check_val("rst_addr", 256'(address_o), 256'd0);
    reset_n = 1'b1;
    tick();

    // Zero-wait read: beats on cycles 2..5, resp_o on cycle 6.
    run_line(1'b1, 1'b0, 32'h0000_1234, '0, 0, 64'h3C, 1'b1, 6);
    check_val("rd_pattern", last_line,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Gapped write: strobes on cycles 3,5,6,9, resp_o on cycle 10.
    run_line(1'b0, 1'b0, 32'h0000_0040,
             {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
             0, 64'h268, 1'b1, 10);

    // Back-to-back read then write with a single idle cycle between.
    run_line(1'b1, 1'b0, 32'h0000_0100, '0, 2, 64'd0, 1'b0, 0);
    rline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_line(1'b0, 1'b0, 32'h0000_0200, rline, 2, 64'd0, 1'b0, 0);

    // Stray memory strobes while idle must be ignored.
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("idle_strobe_ctrl", 256'({read_o, write_o, resp_o}), 256'd0);
      check_val("idle_strobe_line", line_o, last_line);
    end
    resp_i = 1'b0;

    // Both requests high: read wins, monitor flags the violation.
    check_val("illegal_before", 256'(illegal_seen), 256'd0);
    run_line(1'b1, 1'b1, 32'h0000_0ABC, rline, 1, 64'd0, 1'b0, 0);
    check_val("illegal_flag", 256'(illegal_seen), 256'd1);

    // Reset after two beats of a read discards the partial line immediately.
    address_i = 32'h0000_0300;
    read_i    = 1'b1;
    tick();
    resp_i  = 1'b1;
    burst_i = {$urandom | 32'd1, $urandom};
    tick();
    burst_i = {$urandom, $urandom | 32'd1};
    tick();
    resp_i  = 1'b0;
    read_i  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_ctrl", 256'({read_o, write_o, resp_o}), 256'd0);
    check_val("mid_rst_line", line_o, 256'd0);
    check_val("mid_rst_addr", 256'(address_o), 256'd0);
    tick();
    reset_n   = 1'b1;
    last_line = '0;
    tick();
    run_line(1'b1, 1'b0, 32'h0000_0300, '0, 1, 64'd0, 1'b0, 0);

    // Randomized mix of reads and writes with random gaps.
    for (int n = 0; n < 24; n++) begin
      rline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      raddr = $urandom;
      run_line(1'($urandom_range(0, 1)), 1'b0, raddr, rline, int'($urandom_range(0, 3)),
               64'd0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
